opl3_reg_write_arbiter: RTL

- Shares the OPL3 core register-write bus between two requesters:
  - the AXI4-Lite host register port;
  - the on-chip playback sequencer.
- Round-robin arbitration between the two.
- Each write is issued to the core as a single-cycle strobe.
- A programmable idle gap follows every write, giving the core time to settle, as real OPL3 write timing requires.
- Sits between the AXI-Lite slave logic and the opl3 core's register file input.

---
 rtl/opl3_reg_write_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/opl3_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : opl3_reg_write_arbiter
// Description : Round-robin arbiter that shares the OPL3 core register-write
//               bus between the AXI4-Lite host port and the playback
//               sequencer. Each accepted write is issued as a one-cycle
//               strobe, followed by a programmable idle gap so the core
//               has time to settle between writes.
//               Optional macro OPL3_WR_STATS_EN adds saturating per-source
//               write counters (host_wr_count / seq_wr_count).
// Revision    : 1.0 - initial release
// ============================================================================
module opl3_reg_write_arbiter #(
    parameter int GAP_CYCLES = 32,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_bank,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              seq_valid,
    output logic              seq_ready,
    input  logic              seq_bank,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [DATA_W-1:0] seq_data,
    output logic              opl3_we,
    output logic              opl3_bank,
    output logic [ADDR_W-1:0] opl3_addr,
    output logic [DATA_W-1:0] opl3_data,
    output logic              busy,
    output logic              last_grant
`ifdef OPL3_WR_STATS_EN
    ,
    output logic [15:0]       host_wr_count,
    output logic [15:0]       seq_wr_count
`endif
);

    // Gap counter reload value; clamped so GAP_CYCLES=0 never wraps to 0xFFFF.
    localparam int          c_gap_load_int = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [15:0] c_gap_load     = c_gap_load_int[15:0];
    localparam logic        c_src_host     = 1'b0;
    localparam logic        c_src_seq      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic                rr_q, rr_d;
    logic                we_q, we_d;
    logic                bank_q, bank_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_grant_q, last_grant_d;
    logic                busy_q, busy_d;

    logic                host_gnt;
    logic                seq_gnt;
    logic                host_hs;
    logic                seq_hs;

    // Grant selection: only in IDLE and never while reset is asserted, so the
    // ready outputs drop the instant reset arrives.
    always_comb begin
        host_gnt = 1'b0;
        seq_gnt  = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            if (host_valid && (!seq_valid || (rr_q == c_src_host))) begin
                host_gnt = 1'b1;
            end else if (seq_valid) begin
                seq_gnt = 1'b1;
            end
        end
    end

    assign host_ready = host_gnt;
    assign seq_ready  = seq_gnt;
    assign host_hs    = host_valid & host_gnt;
    assign seq_hs     = seq_valid & seq_gnt;

    // Next-state logic for the IDLE -> ISSUE -> GAP sequence and output registers.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        rr_d         = rr_q;
        we_d         = 1'b0;
        bank_d       = bank_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (host_hs) begin
                    bank_d       = host_bank;
                    addr_d       = host_addr;
                    data_d       = host_data;
                    last_grant_d = c_src_host;
                    rr_d         = c_src_seq;
                    we_d         = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (seq_hs) begin
                    bank_d       = seq_bank;
                    addr_d       = seq_addr;
                    data_d       = seq_data;
                    last_grant_d = c_src_seq;
                    rr_d         = c_src_host;
                    we_d         = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = c_gap_load;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = 16'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any strobe or pending gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= 16'd0;
            rr_q         <= c_src_host;
            we_q         <= 1'b0;
            bank_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_grant_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            rr_q         <= rr_d;
            we_q         <= we_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign opl3_we    = we_q;
    assign opl3_bank  = bank_q;
    assign opl3_addr  = addr_q;
    assign opl3_data  = data_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

`ifdef OPL3_WR_STATS_EN
    logic [15:0] host_wr_cnt_q, host_wr_cnt_d;
    logic [15:0] seq_wr_cnt_q, seq_wr_cnt_d;

    // Count issued writes per source; last_grant_q names the source during ISSUE.
    always_comb begin
        host_wr_cnt_d = host_wr_cnt_q;
        seq_wr_cnt_d  = seq_wr_cnt_q;
        if (state_q == ST_ISSUE) begin
            if ((last_grant_q == c_src_host) && (host_wr_cnt_q != 16'hFFFF)) begin
                host_wr_cnt_d = host_wr_cnt_q + 16'd1;
            end
            if ((last_grant_q == c_src_seq) && (seq_wr_cnt_q != 16'hFFFF)) begin
                seq_wr_cnt_d = seq_wr_cnt_q + 16'd1;
            end
        end
    end

    // Saturating statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_wr_cnt_q <= 16'd0;
            seq_wr_cnt_q  <= 16'd0;
        end else begin
            host_wr_cnt_q <= host_wr_cnt_d;
            seq_wr_cnt_q  <= seq_wr_cnt_d;
        end
    end

    assign host_wr_count = host_wr_cnt_q;
    assign seq_wr_count  = seq_wr_cnt_q;
`endif

endmodule
`default_nettype wire
